// File: rtl/control_sequencer.sv
// Microstep sequencer: T-state counter plus opcode/T-state/flag decode into control strobes.
// Optional CONTROL_SEQUENCER_EARLY_FETCH_EN: skip empty trailing execute steps straight to T0.
module control_sequencer #(
  parameter int OPCODE_WIDTH = 4,
  parameter int STEP_COUNT   = 5
) (
  input  logic                    i_CLOCK,
  input  logic                    i_RESET,
  input  logic                    i_STEP_ENABLE,
  input  logic [OPCODE_WIDTH-1:0] i_OPCODE,
  input  logic                    i_CARRY,
  input  logic                    i_ZERO,
  output logic                    o_PC_OUTPUT,
  output logic                    o_PC_COUNT_ENABLE,
  output logic                    o_PC_JUMP,
  output logic                    o_MAR_LOAD,
  output logic                    o_RAM_OUTPUT,
  output logic                    o_RAM_WRITE,
  output logic                    o_IR_LOAD,
  output logic                    o_IR_OUTPUT,
  output logic                    o_A_LOAD,
  output logic                    o_A_OUTPUT,
  output logic                    o_B_LOAD,
  output logic                    o_ALU_OUTPUT,
  output logic                    o_ALU_SUB,
  output logic                    o_FLAGS_LOAD,
  output logic                    o_OUT_LOAD,
  output logic                    o_HALTED,
  output logic [2:0]              o_T_STATE
);

  typedef struct packed {
    logic pc_output, pc_count, pc_jump, mar_load, ram_output, ram_write, ir_load, ir_output;
    logic a_load, a_output, b_load, alu_output, alu_sub, flags_load, out_load;
  } strobes_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_STA = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_JC  = OPCODE_WIDTH'(7);
  localparam logic [OPCODE_WIDTH-1:0] OP_JZ  = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] OP_OUT = OPCODE_WIDTH'(14);
  localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(15);
  localparam logic [2:0]              LAST_T = 3'(STEP_COUNT - 1);

  // Flags only matter in T2, where conditional jumps resolve.
  function automatic strobes_t decode(input logic [2:0] t, input logic [OPCODE_WIDTH-1:0] op,
                                      input logic carry, input logic zero);
    strobes_t s;
    s = '0;
    case (t)
      3'd0: begin s.pc_output = 1'b1; s.mar_load = 1'b1; end
      3'd1: begin s.ram_output = 1'b1; s.ir_load = 1'b1; s.pc_count = 1'b1; end
      3'd2: begin
        case (op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin s.ir_output = 1'b1; s.mar_load = 1'b1; end
          OP_LDI: begin s.ir_output = 1'b1; s.a_load = 1'b1; end
          OP_JMP: begin s.ir_output = 1'b1; s.pc_jump = 1'b1; end
          OP_JC:  begin s.ir_output = carry; s.pc_jump = carry; end
          OP_JZ:  begin s.ir_output = zero;  s.pc_jump = zero;  end
          OP_OUT: begin s.a_output = 1'b1; s.out_load = 1'b1; end
          default: ;
        endcase
      end
      3'd3: begin
        case (op)
          OP_LDA:         begin s.ram_output = 1'b1; s.a_load = 1'b1; end
          OP_ADD, OP_SUB: begin s.ram_output = 1'b1; s.b_load = 1'b1; end
          OP_STA:         begin s.a_output = 1'b1; s.ram_write = 1'b1; end
          default: ;
        endcase
      end
      3'd4: begin
        if (op == OP_ADD || op == OP_SUB) begin
          s.alu_output = 1'b1; s.a_load = 1'b1; s.flags_load = 1'b1;
          s.alu_sub    = (op == OP_SUB);
        end
      end
      default: ;
    endcase
    return s;
  endfunction

  logic [2:0] t_state_q, t_state_d, next_t;
  logic       halted_q, halted_d;
  strobes_t   cur, strobes;

  always_comb begin
    t_state_d = t_state_q;
    halted_d  = halted_q;
    next_t    = (t_state_q == LAST_T) ? 3'd0 : t_state_q + 3'd1;
    cur       = decode(t_state_q, i_OPCODE, i_CARRY, i_ZERO);
    if (i_STEP_ENABLE && !halted_q) begin
      if (t_state_q == 3'd2 && i_OPCODE == OP_HLT)
        halted_d = 1'b1;
`ifdef CONTROL_SEQUENCER_EARLY_FETCH_EN
      // Fetch steps always run; only empty execute steps are skipped.
      else if (t_state_q >= 3'd2 && decode(next_t, i_OPCODE, i_CARRY, i_ZERO) == '0)
        t_state_d = 3'd0;
`endif
      else
        t_state_d = next_t;
    end
    strobes = (i_RESET || halted_q) ? '0 : cur;
  end

  always_ff @(posedge i_CLOCK) begin
    if (i_RESET) begin
      t_state_q <= 3'd0;
      halted_q  <= 1'b0;
    end else begin
      t_state_q <= t_state_d;
      halted_q  <= halted_d;
    end
  end

  assign o_PC_OUTPUT       = strobes.pc_output;
  assign o_PC_COUNT_ENABLE = strobes.pc_count;
  assign o_PC_JUMP         = strobes.pc_jump;
  assign o_MAR_LOAD        = strobes.mar_load;
  assign o_RAM_OUTPUT      = strobes.ram_output;
  assign o_RAM_WRITE       = strobes.ram_write;
  assign o_IR_LOAD         = strobes.ir_load;
  assign o_IR_OUTPUT       = strobes.ir_output;
  assign o_A_LOAD          = strobes.a_load;
  assign o_A_OUTPUT        = strobes.a_output;
  assign o_B_LOAD          = strobes.b_load;
  assign o_ALU_OUTPUT      = strobes.alu_output;
  assign o_ALU_SUB         = strobes.alu_sub;
  assign o_FLAGS_LOAD      = strobes.flags_load;
  assign o_OUT_LOAD        = strobes.out_load;
  assign o_HALTED          = halted_q;
  assign o_T_STATE         = i_RESET ? 3'd0 : t_state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: a behavioural model pushes expected strobes/T-state
// each cycle; scenario tasks pop and compare against the DUT before the next rising edge.
module tb_control_sequencer;
  logic clk = 1'b0;
  logic i_RESET = 1'b1, i_STEP_ENABLE = 1'b0, i_CARRY = 1'b0, i_ZERO = 1'b0;
  logic [3:0] i_OPCODE = 4'd0;
  logic o_PC_OUTPUT, o_PC_COUNT_ENABLE, o_PC_JUMP, o_MAR_LOAD, o_RAM_OUTPUT, o_RAM_WRITE;
  logic o_IR_LOAD, o_IR_OUTPUT, o_A_LOAD, o_A_OUTPUT, o_B_LOAD, o_ALU_OUTPUT, o_ALU_SUB;
  logic o_FLAGS_LOAD, o_OUT_LOAD, o_HALTED;
  logic [2:0] o_T_STATE;

  always #5 clk = ~clk;

  control_sequencer #(.OPCODE_WIDTH(4), .STEP_COUNT(5)) dut (
    .i_CLOCK(clk), .i_RESET(i_RESET), .i_STEP_ENABLE(i_STEP_ENABLE), .i_OPCODE(i_OPCODE),
    .i_CARRY(i_CARRY), .i_ZERO(i_ZERO), .o_PC_OUTPUT(o_PC_OUTPUT),
    .o_PC_COUNT_ENABLE(o_PC_COUNT_ENABLE), .o_PC_JUMP(o_PC_JUMP), .o_MAR_LOAD(o_MAR_LOAD),
    .o_RAM_OUTPUT(o_RAM_OUTPUT), .o_RAM_WRITE(o_RAM_WRITE), .o_IR_LOAD(o_IR_LOAD),
    .o_IR_OUTPUT(o_IR_OUTPUT), .o_A_LOAD(o_A_LOAD), .o_A_OUTPUT(o_A_OUTPUT), .o_B_LOAD(o_B_LOAD),
    .o_ALU_OUTPUT(o_ALU_OUTPUT), .o_ALU_SUB(o_ALU_SUB), .o_FLAGS_LOAD(o_FLAGS_LOAD),
    .o_OUT_LOAD(o_OUT_LOAD), .o_HALTED(o_HALTED), .o_T_STATE(o_T_STATE));

  localparam logic [14:0] PC_OUT = 15'h4000, PC_CNT = 15'h2000, PC_JMP = 15'h1000,
    MAR_LD = 15'h0800, RAM_OUT = 15'h0400, RAM_WR = 15'h0200, IR_LD = 15'h0100,
    IR_OUT = 15'h0080, A_LD = 15'h0040, A_OUT = 15'h0020, B_LD = 15'h0010,
    ALU_OUT = 15'h0008, ALU_SUB = 15'h0004, FLG_LD = 15'h0002, OUT_LD = 15'h0001;

  logic [14:0] got;
  logic [4:0]  bus;
  assign got = {o_PC_OUTPUT, o_PC_COUNT_ENABLE, o_PC_JUMP, o_MAR_LOAD, o_RAM_OUTPUT, o_RAM_WRITE,
                o_IR_LOAD, o_IR_OUTPUT, o_A_LOAD, o_A_OUTPUT, o_B_LOAD, o_ALU_OUTPUT, o_ALU_SUB,
                o_FLAGS_LOAD, o_OUT_LOAD};
  assign bus = {o_PC_OUTPUT, o_RAM_OUTPUT, o_IR_OUTPUT, o_A_OUTPUT, o_ALU_OUTPUT};

  typedef struct { logic [14:0] s; logic [2:0] t; logic h; logic ckh; } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  int mt = 0;
  bit mh = 1'b0;

  function automatic logic [14:0] model_mask(int t, int op, bit c, bit z);
    if (t == 0) return PC_OUT | MAR_LD;
    if (t == 1) return RAM_OUT | IR_LD | PC_CNT;
    if (t == 2) begin
      if (op >= 1 && op <= 4) return IR_OUT | MAR_LD;
      if (op == 5) return IR_OUT | A_LD;
      if (op == 6 || (op == 7 && c) || (op == 8 && z)) return IR_OUT | PC_JMP;
      if (op == 14) return A_OUT | OUT_LD;
      return '0;
    end
    if (t == 3) begin
      if (op == 1) return RAM_OUT | A_LD;
      if (op == 2 || op == 3) return RAM_OUT | B_LD;
      if (op == 4) return A_OUT | RAM_WR;
      return '0;
    end
    if (t == 4 && op == 2) return ALU_OUT | A_LD | FLG_LD;
    if (t == 4 && op == 3) return ALU_OUT | A_LD | FLG_LD | ALU_SUB;
    return '0;
  endfunction

  // Drive one cycle of inputs, push the model's expectation, then advance the model past the edge.
  task automatic drv(input int op, input bit st, input bit c, input bit z, input bit r);
    exp_t e;
    @(negedge clk);
    i_OPCODE = 4'(op); i_STEP_ENABLE = st; i_CARRY = c; i_ZERO = z; i_RESET = r;
    e.ckh = !r; e.h = mh; e.t = r ? 3'd0 : 3'(mt);
    e.s = (r || mh) ? 15'd0 : model_mask(mt, op, c, z);
    sb.push_back(e);
    if (r) begin mt = 0; mh = 1'b0; end
    else if (st && !mh) begin
      if (mt == 2 && op == 15) mh = 1'b1;
      else if (mt == 4) mt = 0;
      else begin
        mt++;
`ifdef CONTROL_SEQUENCER_EARLY_FETCH_EN
        if (mt >= 3 && model_mask(mt, op, c, z) == 15'd0) mt = 0;
`endif
      end
    end
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      drv(5, 1'b1, 1'b1, 1'b1, 1'b1);
      #2; e = sb.pop_front(); checks++;
      if ({got, o_T_STATE} !== {e.s, e.t}) begin
        errors++; $display("FAIL reset got %h/%0d exp %h/%0d", got, o_T_STATE, e.s, e.t);
      end
    end
  endtask

  task automatic test_ldi();
    exp_t e;
    drv(0, 1'b0, 1'b0, 1'b0, 1'b1); void'(sb.pop_front());
    for (int i = 0; i < 6; i++) begin
      drv(5, 1'b1, 1'b0, 1'b0, 1'b0);
      #2; e = sb.pop_front(); checks++;
      if ({got, o_T_STATE, o_HALTED} !== {e.s, e.t, e.h}) begin
        errors++; $display("FAIL ldi cyc%0d got %h/%0d/%b exp %h/%0d/%b", i, got, o_T_STATE, o_HALTED, e.s, e.t, e.h);
      end
    end
  endtask

  // Flag is honoured only in T2; other steps see random flags that must not matter.
  task automatic test_cond_jump();
    exp_t e;
    bit f;
    for (int op = 7; op <= 8; op++)
      for (int fl = 0; fl < 2; fl++) begin
        drv(0, 1'b0, 1'b0, 1'b0, 1'b1); void'(sb.pop_front());
        for (int i = 0; i < 5; i++) begin
          f = (i == 2) ? bit'(fl) : bit'($urandom_range(0, 1));
          drv(op, 1'b1, f, f, 1'b0);
          #2; e = sb.pop_front(); checks++;
          if ({got, o_T_STATE} !== {e.s, e.t}) begin
            errors++; $display("FAIL cjump op%0d flag%0d cyc%0d got %h/%0d exp %h/%0d", op, fl, i, got, o_T_STATE, e.s, e.t);
          end
        end
      end
  endtask

  task automatic test_sub();
    exp_t e;
    drv(0, 1'b0, 1'b0, 1'b0, 1'b1); void'(sb.pop_front());
    for (int i = 0; i < 5; i++) begin
      drv(3, 1'b1, 1'b1, 1'b0, 1'b0);
      #2; e = sb.pop_front(); checks += 2;
      if ({got, o_T_STATE} !== {e.s, e.t}) begin
        errors++; $display("FAIL sub cyc%0d got %h/%0d exp %h/%0d", i, got, o_T_STATE, e.s, e.t);
      end
      if ($countones(bus) > 1) begin
        errors++; $display("FAIL bus_onehot sub cyc%0d got %b exp at most one", i, bus);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    drv(0, 1'b0, 1'b0, 1'b0, 1'b1); void'(sb.pop_front());
    for (int op = 0; op < 15; op++)
      for (int i = 0; i < 5; i++) begin
        drv(op, 1'b1, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b0);
        #2; e = sb.pop_front(); checks += 2;
        if ({got, o_T_STATE, o_HALTED} !== {e.s, e.t, e.h}) begin
          errors++; $display("FAIL b2b op%0d cyc%0d got %h/%0d exp %h/%0d", op, i, got, o_T_STATE, e.s, e.t);
        end
        if ($countones(bus) > 1) begin
          errors++; $display("FAIL bus_onehot op%0d got %b exp at most one", op, bus);
        end
      end
  endtask

  task automatic test_halt();
    exp_t e;
    drv(0, 1'b0, 1'b0, 1'b0, 1'b1); void'(sb.pop_front());
    for (int i = 0; i < 27; i++) begin
      if (i == 24) drv(15, 1'b1, 1'b0, 1'b0, 1'b1);
      else         drv(i < 24 ? 15 : 0, 1'b1, 1'b1, 1'b1, 1'b0);
      #2; e = sb.pop_front(); checks++;
      if ({got, o_T_STATE, o_HALTED & e.ckh} !== {e.s, e.t, e.h & e.ckh}) begin
        errors++; $display("FAIL halt cyc%0d got %h/%0d/%b exp %h/%0d/%b", i, got, o_T_STATE, o_HALTED, e.s, e.t, e.h);
      end
    end
  endtask

  task automatic test_stall();
    exp_t e;
    drv(0, 1'b0, 1'b0, 1'b0, 1'b1); void'(sb.pop_front());
    for (int i = 0; i < 8; i++) begin
      drv(5, !(i >= 1 && i <= 3), 1'b0, 1'b0, 1'b0);
      #2; e = sb.pop_front(); checks++;
      if ({got, o_T_STATE} !== {e.s, e.t}) begin
        errors++; $display("FAIL stall cyc%0d got %h/%0d exp %h/%0d", i, got, o_T_STATE, e.s, e.t);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    drv(0, 1'b0, 1'b0, 1'b0, 1'b1); void'(sb.pop_front());
    for (int i = 0; i < 6; i++) begin
      drv(2, 1'b1, 1'b0, 1'b0, i == 3);
      #2; e = sb.pop_front(); checks++;
      if ({got, o_T_STATE} !== {e.s, e.t}) begin
        errors++; $display("FAIL reset_mid cyc%0d got %h/%0d exp %h/%0d", i, got, o_T_STATE, e.s, e.t);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_cond_jump();
    test_sub();
    test_back_to_back();
    test_halt();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microstep sequencer for the bus-based CPU.
- Holds the T-state counter and decodes the current opcode, T-state and flags into the per-stage control strobes that drive the program counter (count, jump, output), the MAR, RAM, IR, A/B registers, ALU, flags and output register.
- Sits directly upstream of the program counter: it is the only source of the PC's count-enable, jump and output strobes.

Parameters:
OPCODE_WIDTH, 4, width of opcode field taken from instruction register
STEP_COUNT, 5, number of T-states per instruction (T0..T4); min 3

Ports:
i_CLOCK  input  1  system clock, rising edge
i_RESET  input  1  synchronous, active-high reset
i_STEP_ENABLE  input  1  advance T-state this cycle when high; low freezes sequencer (single-step/stall)
i_OPCODE  input  OPCODE_WIDTH  opcode from instruction register (upper nibble of IR)
i_CARRY  input  1  carry flag
i_ZERO  input  1  zero flag
o_PC_OUTPUT  output  1  PC drives bus
o_PC_COUNT_ENABLE  output  1  PC increments
o_PC_JUMP  output  1  PC loads from bus
o_MAR_LOAD  output  1  MAR loads from bus
o_RAM_OUTPUT  output  1  RAM drives bus
o_RAM_WRITE  output  1  RAM writes bus
o_IR_LOAD  output  1  IR loads from bus
o_IR_OUTPUT  output  1  IR operand drives bus
o_A_LOAD, o_A_OUTPUT, o_B_LOAD  output  1 each  register strobes
o_ALU_OUTPUT, o_ALU_SUB  output  1 each  ALU drives bus / subtract select
o_FLAGS_LOAD, o_OUT_LOAD  output  1 each  flags / output register load
o_HALTED  output  1  CPU halted
o_T_STATE  output  3  current T-state (debug)

Behaviour:
- All strobes active-high, combinational decode of (T-state, opcode, flags, halted). T-state and halted are registered.
- Reset (i_RESET high at edge): T-state=0, halted=0. While i_RESET is high, all strobes are forced 0 and o_T_STATE reads 0. Reset mid-instruction aborts it; the next cycle is a T0 fetch.
- T-state advance: on a rising edge with i_STEP_ENABLE=1 and halted=0, T-state increments. T-state STEP_COUNT-1 wraps to 0. i_STEP_ENABLE=0 holds state; strobes stay as decoded (level, not pulsed).
- Fetch, all opcodes:
  - T0: PC_OUTPUT, MAR_LOAD.
  - T1: RAM_OUTPUT, IR_LOAD, PC_COUNT_ENABLE.
- Execute, T2/T3/T4 (unlisted steps assert nothing):
  - 0 NOP: none.
  - 1 LDA: T2 IR_OUTPUT, MAR_LOAD; T3 RAM_OUTPUT, A_LOAD.
  - 2 ADD: T2 IR_OUTPUT, MAR_LOAD; T3 RAM_OUTPUT, B_LOAD; T4 ALU_OUTPUT, A_LOAD, FLAGS_LOAD.
  - 3 SUB: as ADD, plus ALU_SUB in T4.
  - 4 STA: T2 IR_OUTPUT, MAR_LOAD; T3 A_OUTPUT, RAM_WRITE.
  - 5 LDI: T2 IR_OUTPUT, A_LOAD.
  - 6 JMP: T2 IR_OUTPUT, PC_JUMP.
  - 7 JC: T2 IR_OUTPUT, PC_JUMP only if i_CARRY=1, else none.
  - 8 JZ: as JC, using i_ZERO.
  - 14 OUT: T2 A_OUTPUT, OUT_LOAD.
  - 15 HLT: at T2 edge (step enabled), halted<=1.
  - 9–13 undefined: treated as NOP.
- Flags are sampled combinationally during T2; flag changes in other steps have no effect.
- Halted: all strobes 0, T-state frozen at 2, o_HALTED=1. Only i_RESET clears it.
- Invariant: at most one bus-driver strobe (PC_OUTPUT, RAM_OUTPUT, IR_OUTPUT, A_OUTPUT, ALU_OUTPUT) is high in any state.

Optional Feature:
- Macro: CONTROL_SEQUENCER_EARLY_FETCH_EN.
- Defined: when the decoded step for the next T-state asserts no strobe and is not HLT, T-state returns to 0 instead of advancing. NOP, LDI, JMP, untaken JC/JZ and OUT take 3 cycles; LDA and STA take 4; ADD and SUB take 5.
- Undefined: every instruction takes exactly STEP_COUNT cycles.

Test Plan:
- Reset, then i_OPCODE=5, step enable held 1 -> cycle 0: PC_OUTPUT=MAR_LOAD=1; cycle 1: RAM_OUTPUT=IR_LOAD=PC_COUNT_ENABLE=1; cycle 2: IR_OUTPUT=A_LOAD=1; o_T_STATE sequence 0,1,2,3,4,0.
- i_OPCODE=7, i_CARRY=0 then rerun with i_CARRY=1 -> o_PC_JUMP=0 at T2 on the first run, 1 at T2 on the second; same check for opcode 8 with i_ZERO.
- i_OPCODE=3 -> T4: ALU_OUTPUT, ALU_SUB, A_LOAD, FLAGS_LOAD all 1; every state has at most one bus driver high.
- i_OPCODE=15 -> after T2 edge o_HALTED=1, all strobes 0, T-state stays 2 for 20 cycles; i_RESET pulse -> T-state 0, o_HALTED=0.
- i_STEP_ENABLE=0 at T1 for 3 cycles -> T-state holds 1, IR_LOAD stays 1; i_RESET asserted at T3 of ADD -> next cycle T0 fetch strobes.
- With CONTROL_SEQUENCER_EARLY_FETCH_EN: opcode 0 loops T0,T1,T2,T0; opcode 1 loops T0..T3,T0.
